// File: rtl/rr_mux.sv
// Round-robin CHANNELS:1 mux feeding one registered output beat.
// Define RR_MUX_LOCK_EN to add packet lock mode and the in_last port.
module rr_mux #(
  parameter int  WIDTH    = 32,
  parameter int  CHANNELS = 3,
  localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
`ifdef RR_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  input  logic                      out_ready
);

  localparam int              IW      = SELW + 1;
  localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0]     out_sel_q,   out_sel_d;
  logic [SELW-1:0]     ptr_q,       ptr_d;
`ifdef RR_MUX_LOCK_EN
  logic                lock_q,      lock_d;
  logic [SELW-1:0]     lock_ch_q,   lock_ch_d;
`endif

  logic [CHANNELS-1:0] req;
  logic                any_req;
  logic                load_en;
  logic                accept;
  logic [SELW-1:0]     grant;
  logic [SELW-1:0]     grant_nxt;
  logic [WIDTH-1:0]    grant_data;
  logic [IW-1:0]       idx;
  logic                found;

  // While a packet is locked, only the locked channel is eligible.
  always_comb begin
    req = '0;
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef RR_MUX_LOCK_EN
      req[i] = in_valid[i] && (!lock_q || (lock_ch_q == SELW'(i)));
`else
      req[i] = in_valid[i];
`endif
    end
  end

  // First eligible channel at or after ptr, wrapping modulo CHANNELS.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = IW'(ptr_q) + IW'(k);
      if (idx >= IW'(CHANNELS)) begin
        idx = idx - IW'(CHANNELS);
      end
      if (!found && req[idx[SELW-1:0]]) begin
        grant = idx[SELW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    any_req   = |req;
    load_en   = !out_valid_q || out_ready;
    accept    = reset_n && load_en && any_req;
    grant_nxt = (grant == LAST_CH) ? '0 : grant + SELW'(1);
    in_ready  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = accept && (grant == SELW'(i));
    end
  end

  // Data path is kept off the ready path: it only follows the grant.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SELW'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef RR_MUX_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant;
`ifdef RR_MUX_LOCK_EN
      // Pointer moves only when a packet ends, so a packet never interleaves.
      if (in_last[grant]) begin
        lock_d = 1'b0;
        ptr_d  = grant_nxt;
      end else begin
        lock_d    = 1'b1;
        lock_ch_d = grant;
      end
`else
      ptr_d = grant_nxt;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef RR_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: directed scenarios plus randomized traffic against a queue-free
// behavioural arbiter model. Builds with or without RR_MUX_LOCK_EN.
module tb_rr_mux;

  localparam int W  = 32;
  localparam int CH = 3;
  localparam int SW = 2;
`ifdef RR_MUX_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [CH-1:0]   in_valid;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_last;
  logic [CH-1:0]   in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  bit           m_lock;
  int           m_lock_ch;

  rr_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant();
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (m_ptr + k) % CH;
      if (in_valid[c] && (!m_lock || c == m_lock_ch)) return c;
    end
    return -1;
  endfunction

  function automatic logic [CH-1:0] exp_ready();
    int g;
    g = exp_grant();
    if (!reset_n || g < 0 || (m_valid && !out_ready)) return '0;
    return CH'(1) << g;
  endfunction

  task automatic set_data(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  // Advance one clock and move the model along with it.
  task automatic tick();
    int g; bit nv; logic [W-1:0] nd; int ns; int np; bit nl; int nlc;
    nv = m_valid; nd = m_data; ns = m_sel; np = m_ptr; nl = m_lock; nlc = m_lock_ch;
    g = exp_grant();
    if (!reset_n) begin
      nv = 0; nd = '0; ns = 0; np = 0; nl = 0; nlc = 0;
    end else if (g >= 0 && (!m_valid || out_ready)) begin
      nv = 1; nd = in_data[g*W +: W]; ns = g;
      if (!LOCK || in_last[g]) begin
        np = (g + 1) % CH; nl = 0;
      end else begin
        nl = 1; nlc = g;
      end
    end else if (m_valid && out_ready) begin
      nv = 0;
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_data = nd; m_sel = ns; m_ptr = np; m_lock = nl; m_lock_ch = nlc;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = '1; out_ready = 1'b1; in_last = '1;
    set_data(0, 32'd126); set_data(1, 32'd53); set_data(2, 32'd178);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 000", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_sel !== 2'd0) begin
      n_fail++; $display("FAIL reset_out: got v=%b d=%0d s=%0d expected v=0 d=0 s=0", out_valid, out_data, out_sel);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_channel();
    do_reset();
    in_valid = 3'b001; set_data(0, 32'd126); out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready[%0d]: got %b expected 001", c, in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd126 || out_sel !== 2'd0) begin
        n_fail++; $display("FAIL single_out[%0d]: got v=%b d=%0d s=%0d expected v=1 d=126 s=0", c, out_valid, out_data, out_sel);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [CH-1:0] er[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int ed[4] = '{126, 53, 178, 126};
    int es[4] = '{0, 1, 2, 0};
    do_reset();
    in_valid = 3'b111; out_ready = 1'b1;
    set_data(0, 32'd126); set_data(1, 32'd53); set_data(2, 32'd178);
    for (int b = 0; b < 4; b++) begin
      #1;
      n_checks++;
      if (in_ready !== er[b]) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", b, in_ready, er[b]); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== W'(ed[b]) || out_sel !== SW'(es[b])) begin
        n_fail++; $display("FAIL rr_out[%0d]: got v=%b d=%0d s=%0d expected v=1 d=%0d s=%0d", b, out_valid, out_data, out_sel, ed[b], es[b]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 3'b111; out_ready = 1'b1;
    set_data(0, 32'd126); set_data(1, 32'd53); set_data(2, 32'd178);
    tick(); tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 3'b000) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 000", c, in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd53 || out_sel !== 2'd1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b d=%0d s=%0d expected v=1 d=53 s=1", c, out_valid, out_data, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 3'b100) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 100", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd178 || out_sel !== 2'd2) begin
      n_fail++; $display("FAIL stall_release_out: got v=%b d=%0d s=%0d expected v=1 d=178 s=2", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 3'b111; out_ready = 1'b1;
    set_data(0, 32'd126); set_data(1, 32'd53); set_data(2, 32'd178);
    tick(); tick(); tick();
    n_checks++;
    if (out_data !== 32'd178) begin n_fail++; $display("FAIL mid_pre: got d=%0d expected 178", out_data); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 3'b000) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 000", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_sel !== 2'd0) begin
      n_fail++; $display("FAIL mid_reset_out: got v=%b d=%0d s=%0d expected v=0 d=0 s=0", out_valid, out_data, out_sel);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 3'b001) begin n_fail++; $display("FAIL mid_first_grant: got %b expected 001", in_ready); end
    tick();
    n_checks++;
    if (out_data !== 32'd126 || out_sel !== 2'd0) begin
      n_fail++; $display("FAIL mid_first_out: got d=%0d s=%0d expected d=126 s=0", out_data, out_sel);
    end
  endtask

  task automatic test_drain_idle();
    do_reset();
    in_valid = 3'b001; out_ready = 1'b1; set_data(0, 32'd5); set_data(2, 32'd178);
    tick();
    in_valid = 3'b000;
    #1;
    n_checks++;
    if (in_ready !== 3'b000) begin n_fail++; $display("FAIL drain_ready: got %b expected 000", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
    // ptr now sits at 1; a lone ch2 request must still win every cycle
    in_valid = 3'b100;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 3'b100) begin n_fail++; $display("FAIL idle_single_ready[%0d]: got %b expected 100", c, in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd178 || out_sel !== 2'd2) begin
        n_fail++; $display("FAIL idle_single_out[%0d]: got v=%b d=%0d s=%0d expected v=1 d=178 s=2", c, out_valid, out_data, out_sel);
      end
    end
  endtask

`ifdef RR_MUX_LOCK_EN
  task automatic test_lock();
    int vals[3] = '{97, 299, 14};
    do_reset();
    in_last = 3'b111; out_ready = 1'b1;
    in_valid = 3'b001; set_data(0, 32'd126);
    tick();
    in_valid = 3'b111; set_data(2, 32'd178);
    for (int b = 0; b < 3; b++) begin
      set_data(1, W'(vals[b]));
      in_last[1] = (b == 2);
      #1;
      n_checks++;
      if (in_ready !== 3'b010) begin n_fail++; $display("FAIL lock_ready[%0d]: got %b expected 010", b, in_ready); end
      tick();
      n_checks++;
      if (out_data !== W'(vals[b]) || out_sel !== 2'd1) begin
        n_fail++; $display("FAIL lock_out[%0d]: got d=%0d s=%0d expected d=%0d s=1", b, out_data, out_sel, vals[b]);
      end
    end
    #1;
    n_checks++;
    if (in_ready !== 3'b100) begin n_fail++; $display("FAIL lock_release_ready: got %b expected 100", in_ready); end
    tick();
    n_checks++;
    if (out_data !== 32'd178 || out_sel !== 2'd2) begin
      n_fail++; $display("FAIL lock_release_out: got d=%0d s=%0d expected d=178 s=2", out_data, out_sel);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset_n   = ($urandom_range(0, 59) != 0);
      in_valid  = CH'($urandom_range(0, 7));
      in_last   = CH'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < CH; i++) set_data(i, W'($urandom));
      #1;
      n_checks++;
      if (in_ready !== exp_ready()) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, in_ready, exp_ready());
      end
      tick();
      n_checks++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== SW'(m_sel)))) begin
        n_fail++; $display("FAIL rand_out[%0d]: got v=%b d=%0h s=%0d expected v=%b d=%0h s=%0d",
                           c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = '0; in_data = '0; in_last = '1; out_ready = 1'b0;
    m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_lock = 0; m_lock_ch = 0;
    test_reset();
    test_single_channel();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_drain_idle();
`ifdef RR_MUX_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
